// File: rtl/sram_ctrl_pkg.sv
// Shared timing constants, FSM state type and the ns->cycle helper for the
// async SRAM controller.
package sram_ctrl_pkg;

  // Async SRAM datasheet timings in ns.
  localparam int T_RC  = 55;  // read cycle
  localparam int T_WC  = 55;  // write cycle
  localparam int T_PWE = 40;  // write-enable pulse width

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_TURN  = 2'd3
  } state_e;

  // Ceiling division. A non-positive period is caught by the optional
  // checks; return 1 so elaboration never divides by zero.
  function automatic int cdiv(input int num, input int den);
    if (den <= 0) return 1;
    return (num + den - 1) / den;
  endfunction

endpackage

// File: rtl/avalon_mm_if.sv
// Minimal Avalon-MM bus with pipelined reads (readdatavalid) and waitrequest.
interface avalon_mm_if #(
  parameter int ADDR_W = 18,
  parameter int DATA_W = 16
);
  logic [ADDR_W-1:0] address;
  logic              read;
  logic              write;
  logic [DATA_W-1:0] writedata;
  logic [DATA_W-1:0] readdata;
  logic              readdatavalid;
  logic              waitrequest;

  modport slave  (input  address, read, write, writedata,
                  output readdata, readdatavalid, waitrequest);
  modport master (output address, read, write, writedata,
                  input  readdata, readdatavalid, waitrequest);
endinterface

// File: rtl/sram_controller.sv
// Avalon-MM to asynchronous SRAM controller. One access at a time; the
// access length in cycles is derived from the SRAM ns timings and the clock
// period. Every SRAM-side output comes straight from a flop.
// Optional macro SRAM_CTRL_CHECK_EN compiles in simulation assertions.
import sram_ctrl_pkg::*;

module sram_controller #(
  parameter int CLK_PERIOD = 10,
  parameter int ADDR_W     = 18,
  parameter int DATA_W     = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  avalon_mm_if.slave        mem_if,
  output logic              wen_o,
  output logic              oen_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic              data_en_o,
  output logic [DATA_W-1:0] data_o,
  input  logic [DATA_W-1:0] data_i
);

  localparam int RD_RAW  = cdiv(T_RC, CLK_PERIOD);
  localparam int RD_CYC  = (RD_RAW < 2) ? 2 : RD_RAW;
  localparam int WE_CYC  = cdiv(T_PWE, CLK_PERIOD);
  localparam int WR_RAW  = cdiv(T_WC, CLK_PERIOD);
  // Need one setup and at least one hold cycle around the WE pulse.
  localparam int WR_CYC  = (WR_RAW > WE_CYC + 2) ? WR_RAW : WE_CYC + 2;
  localparam int MAX_CYC = (WR_CYC > RD_CYC) ? WR_CYC : RD_CYC;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(RD_CYC - 1);
  localparam logic [CNT_W-1:0] WR_LAST = CNT_W'(WR_CYC - 1);
  localparam logic [CNT_W-1:0] WE_LAST = CNT_W'(WE_CYC);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_inc;
  logic               wen_q, wen_d;
  logic               oen_q, oen_d;
  logic               den_q, den_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [DATA_W-1:0]  wdat_q, wdat_d;
  logic [DATA_W-1:0]  rdat_q, rdat_d;
  logic               rdv_q, rdv_d;

  assign cnt_inc = cnt_q + CNT_W'(1);

  // Next-state and next-output logic; the cycle index inside an access is cnt_q.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wen_d   = wen_q;
    oen_d   = oen_q;
    den_d   = den_q;
    addr_d  = addr_q;
    wdat_d  = wdat_q;
    rdat_d  = rdat_q;
    rdv_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // Write has priority; a simultaneous read is simply dropped.
        if (mem_if.write) begin
          state_d = ST_WRITE;
          cnt_d   = '0;
          den_d   = 1'b1;
          addr_d  = mem_if.address;
          wdat_d  = mem_if.writedata;
        end else if (mem_if.read) begin
          state_d = ST_READ;
          cnt_d   = '0;
          oen_d   = 1'b0;
          addr_d  = mem_if.address;
          wdat_d  = mem_if.writedata;
        end
      end
      ST_READ: begin
        if (cnt_q == RD_LAST) begin
          state_d = ST_TURN;
          oen_d   = 1'b1;
          rdat_d  = data_i;
          rdv_d   = 1'b1;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      // One dead cycle so the SRAM releases DQ before we may drive it.
      ST_TURN: state_d = ST_IDLE;
      ST_WRITE: begin
        if (cnt_q == WR_LAST) begin
          state_d = ST_IDLE;
          wen_d   = 1'b1;
          den_d   = 1'b0;
        end else begin
          cnt_d = cnt_inc;
          // WE low for cycles 1..WE_CYC, high for setup and hold.
          wen_d = (cnt_inc > WE_LAST);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      wen_q   <= 1'b1;
      oen_q   <= 1'b1;
      den_q   <= 1'b0;
      addr_q  <= '0;
      wdat_q  <= '0;
      rdat_q  <= '0;
      rdv_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wen_q   <= wen_d;
      oen_q   <= oen_d;
      den_q   <= den_d;
      addr_q  <= addr_d;
      wdat_q  <= wdat_d;
      rdat_q  <= rdat_d;
      rdv_q   <= rdv_d;
    end
  end

  assign wen_o                = wen_q;
  assign oen_o                = oen_q;
  assign data_en_o            = den_q;
  assign addr_o               = addr_q;
  assign data_o               = wdat_q;
  assign mem_if.readdata      = rdat_q;
  assign mem_if.readdatavalid = rdv_q;
  // Stall everything during reset so nothing is accepted while held.
  assign mem_if.waitrequest   = rst_i | (state_q != ST_IDLE);

`ifdef SRAM_CTRL_CHECK_EN
  logic              chk_pend_q;
  logic [ADDR_W-1:0] chk_addr_q;
  logic [DATA_W-1:0] chk_wdat_q;
  logic              chk_rd_q, chk_wr_q;

  // Remember the command presented while the bus was stalled.
  always_ff @(posedge clk_i) begin
    chk_pend_q <= !rst_i && mem_if.waitrequest && (mem_if.read || mem_if.write);
    chk_addr_q <= mem_if.address;
    chk_wdat_q <= mem_if.writedata;
    chk_rd_q   <= mem_if.read;
    chk_wr_q   <= mem_if.write;
  end

  // Bus protocol and SRAM pin-safety checks.
  always @(posedge clk_i) begin
    if (!rst_i) begin
      assert (CLK_PERIOD > 0) else $error("CLK_PERIOD must be positive");
      assert (!(mem_if.read && mem_if.write)) else $error("read and write together");
      if (chk_pend_q) begin
        assert (mem_if.address == chk_addr_q && mem_if.writedata == chk_wdat_q &&
                mem_if.read == chk_rd_q && mem_if.write == chk_wr_q)
          else $error("command changed while stalled");
      end
      assert (!(!wen_q && !oen_q)) else $error("WE and OE both low");
      assert (!(den_q && !oen_q)) else $error("DQ driven while OE low");
    end
  end
`endif

endmodule

// File: tb/tb_sram_controller.sv
// Bench for sram_controller at CLK_PERIOD=10 against a 256Kx16 SRAM model.
// Reads are scored through an expected-data queue; pin-level safety and the
// WE pulse width are watched continuously.
module tb_sram_controller;
  localparam int AW = 18;
  localparam int DW = 16;
  localparam int WE_CYC = 4;

  logic clk = 1'b0;
  logic rst;
  logic wen, oen, den;
  logic [AW-1:0] addr;
  logic [DW-1:0] dout, din;

  avalon_mm_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  sram_controller #(.CLK_PERIOD(10), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk_i(clk), .rst_i(rst), .mem_if(bus),
    .wen_o(wen), .oen_o(oen), .addr_o(addr), .data_en_o(den),
    .data_o(dout), .data_i(din)
  );

  always #5 clk = ~clk;

  // SRAM model: writes land while WE is low; DQ reads back only while OE low.
  logic [DW-1:0] mem [0:(1<<AW)-1];
  always @(posedge clk) if (wen === 1'b0 && den === 1'b1) mem[addr] <= dout;
  assign din = (oen === 1'b0) ? mem[addr] : 16'hDEAD;

  int n_chk = 0, n_pass = 0, viol = 0, run = 0;
  bit taint = 0, prev_rdv = 0;
  logic [AW-1:0] pa;
  logic [DW-1:0] pd;
  logic [DW-1:0] exp_q [$];
  logic [DW-1:0] ref_mem [int];

  typedef struct {
    bit            rd;
    bit            wr;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic [DW-1:0] e;
  } vec_t;
  vec_t tbl [8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [DW-1:0] ref_rd(input logic [AW-1:0] a);
    return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : '0;
  endfunction

  task automatic wait_idle();
    int j = 0;
    while (bus.waitrequest !== 1'b0 && j < 100) begin @(negedge clk); j++; end
    if (bus.waitrequest !== 1'b0) chk("wait_idle_timeout", 64'(j), 64'(0));
  endtask

  // One command, accepted on the next edge; reads queue their expected data.
  task automatic issue(input bit rd, input bit wr, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, input bit use_e, input logic [DW-1:0] e);
    @(negedge clk);
    wait_idle();
    bus.read = rd; bus.write = wr; bus.address = a; bus.writedata = d;
    @(posedge clk);
    if (wr) ref_mem[int'(a)] = d;
    else if (rd) exp_q.push_back(use_e ? e : ref_rd(a));
    @(negedge clk);
    bus.read = 1'b0; bus.write = 1'b0;
  endtask

  // Pin monitor and read scoreboard.
  always @(negedge clk) begin
    if (wen === 1'b0 && oen === 1'b0) viol++;
    if (den === 1'b1 && oen === 1'b0) viol++;
    if (wen === 1'b0 && den !== 1'b1) viol++;
    if (wen === 1'b0) begin
      if (run > 0 && (addr !== pa || dout !== pd)) viol++;
      run++; pa = addr; pd = dout;
      if (rst) taint = 1;
    end else if (run > 0) begin
      if (!taint && !rst) chk("wen_low_cycles", 64'(run), 64'(WE_CYC));
      run = 0; taint = 0;
    end
    if (bus.readdatavalid === 1'b1) begin
      if (prev_rdv) viol++;
      if (exp_q.size() == 0) chk("unexpected_readdatavalid", 64'(1), 64'(0));
      else chk("readdata", 64'(bus.readdata), 64'(exp_q.pop_front()));
    end
    prev_rdv = (bus.readdatavalid === 1'b1);
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int j, rdv_at;
    logic [1:0] turn_bits;
    logic [AW-1:0] ra;
    bit rd;

    tbl[0] = '{rd:0, wr:1, a:18'h00010, d:16'h1234, e:16'h0000};
    tbl[1] = '{rd:1, wr:0, a:18'h00010, d:16'h0000, e:16'h1234};
    tbl[2] = '{rd:0, wr:1, a:18'h3FFFF, d:16'hFFFF, e:16'h0000};
    tbl[3] = '{rd:0, wr:1, a:18'h00000, d:16'h0000, e:16'h0000};
    tbl[4] = '{rd:1, wr:0, a:18'h3FFFF, d:16'h0000, e:16'hFFFF};
    tbl[5] = '{rd:1, wr:0, a:18'h00000, d:16'h0000, e:16'h0000};
    tbl[6] = '{rd:1, wr:1, a:18'h00100, d:16'hA5A5, e:16'h0000};
    tbl[7] = '{rd:1, wr:0, a:18'h00100, d:16'h0000, e:16'hA5A5};

    for (int i = 0; i < (1 << AW); i++) mem[i] = '0;
    bus.read = 0; bus.write = 0; bus.address = '0; bus.writedata = '0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_outputs",
        64'({wen, oen, den, addr, dout, bus.readdata, bus.readdatavalid, bus.waitrequest}),
        64'({1'b1, 1'b1, 1'b0, 18'h0, 16'h0, 16'h0, 1'b0, 1'b1}));
    rst = 1'b0;

    // Directed vectors: basic, extreme addresses, write-wins collision.
    for (int i = 0; i < 8; i++)
      issue(tbl[i].rd, tbl[i].wr, tbl[i].a, tbl[i].d, 1'b1, tbl[i].e);

    // Back-to-back write, read, write with each next command held pending.
    @(negedge clk);
    wait_idle();
    bus.write = 1; bus.read = 0; bus.address = 18'h00200; bus.writedata = 16'h5A5A;
    @(posedge clk);
    ref_mem[32'h200] = 16'h5A5A;
    @(negedge clk);
    bus.write = 0; bus.read = 1; bus.address = 18'h00200;
    j = 0;
    while (bus.waitrequest && j < 40) begin @(negedge clk); j++; end
    chk("write_to_next_accept", 64'(j + 1), 64'(7));
    @(posedge clk);
    exp_q.push_back(16'h5A5A);
    @(negedge clk);
    bus.read = 0; bus.write = 1; bus.address = 18'h00201; bus.writedata = 16'hC3C3;
    j = 0; rdv_at = 0; turn_bits = 2'b00;
    while (bus.waitrequest && j < 40) begin
      @(negedge clk); j++;
      if (bus.readdatavalid && rdv_at == 0) begin rdv_at = j; turn_bits = {oen, den}; end
    end
    chk("read_to_readdatavalid", 64'(rdv_at + 1), 64'(7));
    chk("read_to_next_accept", 64'(j + 1), 64'(8));
    chk("turn_cycle_oen_den", 64'(turn_bits), 64'(2'b10));
    @(posedge clk);
    ref_mem[32'h201] = 16'hC3C3;
    @(negedge clk);
    bus.write = 0;
    issue(1'b1, 1'b0, 18'h00201, '0, 1'b1, 16'hC3C3);

    // Reset during cycle 3 of a write, then a command on the first free edge.
    @(negedge clk);
    wait_idle();
    bus.write = 1; bus.address = 18'h00300; bus.writedata = 16'hBEEF;
    @(posedge clk);
    @(negedge clk);
    bus.write = 0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("reset_abort", 64'({wen, den, bus.waitrequest, bus.readdatavalid}), 64'(4'b1010));
    // The WE pulse had already reached the array before the abort.
    ref_mem[32'h300] = 16'hBEEF;
    @(negedge clk);
    rst = 1'b0;
    bus.read = 1; bus.address = 18'h00300;
    @(posedge clk);
    exp_q.push_back(16'hBEEF);
    @(negedge clk);
    bus.read = 0;
    chk("accept_after_reset", 64'({bus.waitrequest, oen}), 64'(2'b10));

    // Random traffic, half of it on a small address window to get hits.
    for (int i = 0; i < 100; i++) begin
      rd = bit'($urandom_range(0, 1));
      ra = (i % 2 == 1) ? AW'($urandom_range(0, 31)) : AW'($urandom);
      issue(rd, !rd, ra, DW'($urandom), 1'b0, '0);
    end

    j = 0;
    while ((exp_q.size() != 0 || bus.waitrequest) && j < 100) begin @(negedge clk); j++; end
    chk("scoreboard_drained", 64'(exp_q.size()), 64'(0));
    chk("bus_violations", 64'(viol), 64'(0));
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
